// File: rtl/fcart_pkg.sv
// Shared definitions for the cartridge SPI link and its consumers.
//   BYTE_W / CNT_W : serial byte width and bit-counter width.
//   CMD_*          : command byte codes carried in the first byte of a
//                    transaction, decoded by the consumer of spi_link.
package fcart_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    localparam logic [BYTE_W-1:0] CMD_READ_MEM  = 8'h00;
    localparam logic [BYTE_W-1:0] CMD_WRITE_MEM = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_READ_REG  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_WRITE_REG = 8'h03;

endpackage

// File: rtl/spi_link_sync_ff.sv
// Pad-input synchronizer: a DEPTH-long flip-flop chain that brings an
// asynchronous pin into the clk domain.
//   clk, reset_n : system clock, synchronous active-low reset
//   d            : asynchronous pad input
//   q            : synchronized output (DEPTH clk cycles of latency)
// On reset every stage holds RST_VAL so the output looks like an idle pin.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stages <= {DEPTH{RST_VAL}};
        end else begin
            stages <= (stages << 1) | DEPTH'(d);
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_link.sv
// SPI mode-0 slave link (MSB first) running entirely in the clk domain.
//   clk, reset_n        : system clock, synchronous active-low reset
//   spi_sck/cs_n/mosi   : asynchronous pads from the MCU
//   spi_miso/miso_oe    : serial reply and its pad output enable
//   start               : 1-cycle pulse at each transaction start
//   rd_data/rd_valid    : last received byte and its 1-cycle update pulse
//   wr_valid/wr_data    : request for the next reply byte / the reply byte;
//                         wr_data must be stable by the sck falling edge
//                         that closes the byte which raised wr_valid
module spi_link
    import fcart_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_HALF_SCK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              start,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_valid,
    input  logic [BYTE_W-1:0] wr_data
);

    localparam int HOLD_W = $clog2(SYNC_STAGES + 1);

    // Edge detection needs every sck level to be seen at least once by the
    // synchronized copy and its delayed copy.
    if (SYNC_STAGES < 1 || MIN_HALF_SCK < 2) begin : g_param_check
        $error("spi_link: SYNC_STAGES must be >= 1 and MIN_HALF_SCK >= 2");
    end

    logic cs_sync, sck_sync, mosi_sync;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d(spi_cs_n), .q(cs_sync));
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d(spi_sck), .q(sck_sync));
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_sync));

    // ---- stage p0: delayed copies, edge detect, arming ----
    logic              cs_dly_p0, sck_dly_p0;
    logic [HOLD_W-1:0] holdoff;
    logic              armed;

    // After reset the synchronizers hold idle values that do not reflect
    // the pins. The link only arms once the flushed chain shows cs_n high,
    // so a reset in the middle of a transaction cannot fake a cs_n fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_dly_p0  <= 1'b1;
            sck_dly_p0 <= 1'b0;
            holdoff    <= HOLD_W'(SYNC_STAGES);
            armed      <= 1'b0;
        end else begin
            cs_dly_p0  <= cs_sync;
            sck_dly_p0 <= sck_sync;
            if (holdoff != '0) begin
                holdoff <= holdoff - HOLD_W'(1);
            end
            armed <= armed | ((holdoff == '0) & cs_sync);
        end
    end

    logic cs_fall, cs_rise, in_xfer, sck_rise, sck_fall;

    assign cs_fall  = armed & ~cs_sync & cs_dly_p0;
    assign cs_rise  = armed & cs_sync & ~cs_dly_p0;
    assign in_xfer  = armed & ~cs_sync;
    // A cs_n fall in the same cycle masks any sck edge.
    assign sck_rise = in_xfer & ~cs_fall & sck_sync & ~sck_dly_p0;
    assign sck_fall = in_xfer & ~cs_fall & ~sck_sync & sck_dly_p0;

    // ---- stage p1: bit counter, rx/tx shift, byte completion ----
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-2:0] rx_shift;
    logic [BYTE_W-1:0] tx_shift;
    logic              tx_load;
    logic              vld_p1;

    always_ff @(posedge clk) begin
        if (cs_fall) begin
            rx_shift <= '0;
        end else if (sck_rise) begin
            rx_shift <= {rx_shift[BYTE_W-3:0], mosi_sync};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            tx_load     <= 1'b0;
            tx_shift    <= '0;
            rd_data     <= '0;
            vld_p1      <= 1'b0;
            start       <= 1'b0;
            rd_valid    <= 1'b0;
            wr_valid    <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            start  <= cs_fall;
            vld_p1 <= sck_rise & (bit_cnt == CNT_W'(BYTE_W - 1));

            if (cs_fall || cs_rise) begin
                bit_cnt <= '0;
                tx_load <= 1'b0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                    rd_data <= {rx_shift, mosi_sync};
                    tx_load <= 1'b1;
                end
            end else if (sck_fall) begin
                tx_load <= 1'b0;
            end

            // The falling edge right after a completed byte places the
            // reply MSB on MISO ahead of the next byte's first rising edge.
            if (cs_fall) begin
                tx_shift <= '0;
            end else if (sck_fall) begin
                tx_shift <= tx_load ? wr_data : (tx_shift << 1);
            end

            // ---- stage p2: output pulses and MISO pad ----
            rd_valid    <= vld_p1;
            wr_valid    <= rd_valid;
            spi_miso_oe <= in_xfer;
            spi_miso    <= in_xfer & ~cs_fall & tx_shift[BYTE_W-1];
        end
    end

endmodule

// File: tb/tb_spi_link.sv
// Directed bench for spi_link: two instances (SYNC_STAGES 2 and 3) share
// the pad stimulus; MISO is checked on the 2-stage instance.
module tb_spi_link;
    import fcart_pkg::*;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       reset_n, spi_sck, spi_cs_n, spi_mosi;
    logic [7:0] wr_data;

    logic       miso2, oe2, start2, rdv2, wrv2;
    logic [7:0] rd2;
    logic       miso3, oe3, start3, rdv3, wrv3;
    logic [7:0] rd3;

    spi_link #(.SYNC_STAGES(2), .MIN_HALF_SCK(HALF)) dut2 (
        .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso2), .spi_miso_oe(oe2),
        .start(start2), .rd_data(rd2), .rd_valid(rdv2), .wr_valid(wrv2),
        .wr_data(wr_data));

    spi_link #(.SYNC_STAGES(3), .MIN_HALF_SCK(HALF)) dut3 (
        .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso3), .spi_miso_oe(oe3),
        .start(start3), .rd_data(rd3), .rd_valid(rdv3), .wr_valid(wrv3),
        .wr_data(wr_data));

    always #5 clk = ~clk;

    // Pulse counters; wr_valid must equal the previous cycle's rd_valid.
    int n_start2 = 0, n_rdv2 = 0, n_wrv2 = 0, n_start3 = 0, n_rdv3 = 0, n_wrv3 = 0;
    int wrv_bad = 0;
    logic rdv2_d = 1'b0, rdv3_d = 1'b0;

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            if (start2 === 1'b1) n_start2 <= n_start2 + 1;
            if (rdv2 === 1'b1)   n_rdv2   <= n_rdv2 + 1;
            if (wrv2 === 1'b1)   n_wrv2   <= n_wrv2 + 1;
            if (start3 === 1'b1) n_start3 <= n_start3 + 1;
            if (rdv3 === 1'b1)   n_rdv3   <= n_rdv3 + 1;
            if (wrv3 === 1'b1)   n_wrv3   <= n_wrv3 + 1;
            if (wrv2 !== rdv2_d || wrv3 !== rdv3_d) wrv_bad <= wrv_bad + 1;
        end
        rdv2_d <= rdv2;
        rdv3_d <= rdv3;
    end

    int checks = 0;
    int fails  = 0;
    int b_start2, b_rdv2, b_wrv2, b_start3, b_rdv3, b_wrv3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_start2 = n_start2; b_rdv2 = n_rdv2; b_wrv2 = n_wrv2;
        b_start3 = n_start3; b_rdv3 = n_rdv3; b_wrv3 = n_wrv3;
    endtask

    // Sends v[7] down to v[8-n]; mb collects MISO sampled just before each
    // rising edge. On the 8th bit, l2/l3 record clk cycles to rd_valid.
    task automatic send_bits(input logic [7:0] v, input int n,
                             output logic [7:0] mb, output int l2, output int l3);
        mb = 8'h00;
        l2 = -1;
        l3 = -1;
        for (int i = 7; i >= 8 - n; i--) begin
            spi_mosi = v[i];
            wait_clk(HALF);
            mb[i] = miso2;
            spi_sck = 1'b1;
            if (i == 0) begin
                for (int c = 1; c <= 2 * HALF; c++) begin
                    wait_clk(1);
                    if (rdv2 === 1'b1 && l2 < 0) l2 = c;
                    if (rdv3 === 1'b1 && l3 < 0) l3 = c;
                end
            end else begin
                wait_clk(HALF);
            end
            spi_sck = 1'b0;
        end
        wait_clk(HALF);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        wait_clk(HALF + 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mb;
        int l2, l3;
        logic seen;

        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        wr_data  = 8'h00;
        wait_clk(3);
        check("rst_start", start2, 1'b0);
        check("rst_rdv", rdv2, 1'b0);
        check("rst_wrv", wrv2, 1'b0);
        check("rst_rd_data", rd2, 8'h00);
        check("rst_miso", miso2, 1'b0);
        check("rst_oe", oe2, 1'b0);
        reset_n = 1'b1;
        wait_clk(6);

        // Single byte A5
        snap();
        cs_low();
        check("oe_cs_low", oe2, 1'b1);
        send_bits(8'hA5, 8, mb, l2, l3);
        check("a5_start", n_start2 - b_start2, 1);
        check("a5_rdv", n_rdv2 - b_rdv2, 1);
        check("a5_wrv", n_wrv2 - b_wrv2, 1);
        check("a5_rd_data", rd2, 8'hA5);
        check("a5_rd_data_s3", rd3, 8'hA5);
        check("a5_miso_byte0", mb, 8'h00);
        check("lat_sync2", l2, 4);
        check("lat_sync3", l3, 5);
        cs_high();
        check("oe_cs_high", oe2, 1'b0);
        check("a5_no_extra_start", n_start2 - b_start2, 1);

        // Three-byte transfer with replies 3C, C3
        snap();
        wr_data = 8'h3C;
        cs_low();
        send_bits(8'h11, 8, mb, l2, l3);
        check("x3_miso0", mb, 8'h00);
        wr_data = 8'hC3;
        send_bits(8'h22, 8, mb, l2, l3);
        check("x3_miso1", mb, 8'h3C);
        check("x3_rd1", rd2, 8'h22);
        wr_data = 8'hFF;
        send_bits(8'h33, 8, mb, l2, l3);
        check("x3_miso2", mb, 8'hC3);
        check("x3_rd2", rd2, 8'h33);
        check("x3_rd2_s3", rd3, 8'h33);
        check("x3_rdv", n_rdv2 - b_rdv2, 3);
        check("x3_wrv", n_wrv2 - b_wrv2, 3);
        check("x3_wrv_s3", n_wrv3 - b_wrv3, 3);
        cs_high();

        // Partial byte (5 bits) discarded, then a fresh byte 01
        snap();
        cs_low();
        send_bits(8'hFF, 5, mb, l2, l3);
        check("part_miso_zero", mb, 8'h00);
        cs_high();
        check("part_rdv", n_rdv2 - b_rdv2, 0);
        check("part_wrv", n_wrv2 - b_wrv2, 0);
        check("part_rd_hold", rd2, 8'h33);
        cs_low();
        send_bits(CMD_WRITE_MEM, 8, mb, l2, l3);
        check("part_new_rd", rd2, CMD_WRITE_MEM);
        check("part_new_rd_s3", rd3, CMD_WRITE_MEM);
        check("part_starts", n_start2 - b_start2, 2);
        check("part_rdv_after", n_rdv2 - b_rdv2, 1);
        cs_high();

        // sck activity with cs_n high is ignored
        snap();
        spi_mosi = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spi_sck = 1'b1;
            wait_clk(HALF);
            seen = seen | oe2 | miso2;
            spi_sck = 1'b0;
            wait_clk(HALF);
        end
        wait_clk(HALF);
        check("idle_oe_miso", seen, 1'b0);
        check("idle_rdv", n_rdv2 - b_rdv2, 0);
        check("idle_start", n_start2 - b_start2, 0);
        check("idle_rd_hold", rd2, CMD_WRITE_MEM);

        // Reset after 12 bits of a transaction
        cs_low();
        send_bits(8'h55, 8, mb, l2, l3);
        check("rr_byte0", rd2, 8'h55);
        send_bits(8'hF0, 4, mb, l2, l3);
        reset_n = 1'b0;
        wait_clk(2);
        check("rr_rd_data", rd2, 8'h00);
        check("rr_oe", oe2, 1'b0);
        check("rr_miso", miso2, 1'b0);
        check("rr_pulses", {start2, rdv2, wrv2}, 3'b000);
        reset_n = 1'b1;
        snap();
        send_bits(8'h00, 4, mb, l2, l3);
        send_bits(8'hAA, 8, mb, l2, l3);
        check("rr_tail_pulses", (n_start2 - b_start2) + (n_rdv2 - b_rdv2) + (n_wrv2 - b_wrv2), 0);
        check("rr_tail_pulses_s3", (n_start3 - b_start3) + (n_rdv3 - b_rdv3) + (n_wrv3 - b_wrv3), 0);
        check("rr_tail_oe", oe2, 1'b0);
        check("rr_tail_rd", rd2, 8'h00);
        cs_high();
        snap();
        cs_low();
        send_bits(CMD_READ_REG, 8, mb, l2, l3);
        check("rr_next_rd", rd2, CMD_READ_REG);
        check("rr_next_rd_s3", rd3, CMD_READ_REG);
        check("rr_next_start", n_start2 - b_start2, 1);
        check("rr_next_rdv", n_rdv2 - b_rdv2, 1);
        cs_high();

        check("wrv_follows_rdv", wrv_bad, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/spi_link.md
SPI_LINK -- requirements
Module: spi_link

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flop stages on each pad input.
REQ-002 SHALL have parameter MIN_HALF_SCK, default 4: minimum SCK half-period in clk cycles, used only by verification checks.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic in this one domain.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset, sampled on posedge clk.
REQ-005 SHALL have ports spi_sck, spi_cs_n and spi_mosi, each input, 1: SPI pads from the MCU (mode 0, MSB first).
REQ-006 SHALL have port spi_miso, output, 1: serial data to the MCU.
REQ-007 SHALL have port spi_miso_oe, output, 1: output enable for the MISO pad, driven by the top level.
REQ-008 SHALL have port start, output, 1: one-cycle pulse at the start of each transaction.
REQ-009 SHALL have port rd_data, output, 8: the last fully received byte.
REQ-010 SHALL have port rd_valid, output, 1: one-cycle pulse when rd_data is updated.
REQ-011 SHALL have port wr_valid, output, 1: one-cycle pulse requesting the next transmit byte.
REQ-012 SHALL have port wr_data, input, 8: transmit byte supplied by the consumer.

Function
REQ-013 Each pad input SHALL pass through SYNC_STAGES flip-flops; edges SHALL be detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-014 A detected cs_n falling edge SHALL pulse start for 1 cycle and clear bit_cnt (3 bits) and the rx shift register.
REQ-015 While synchronized cs_n is low, each sck rising edge SHALL shift synchronized mosi into rx_shift LSB (MSB-first) and increment bit_cnt; bit_cnt wraps 7->0.
REQ-016 On the rising edge where bit_cnt wraps 7->0, rd_data SHALL load the completed byte and rd_valid SHALL pulse in the following cycle; rd_data holds until the next byte completes.
REQ-017 wr_valid SHALL pulse exactly one cycle after each rd_valid pulse; no wr_valid before the first completed byte.
REQ-018 wr_data SHALL be sampled into tx_shift on the first sck falling edge after a byte completes; that byte SHALL be transmitted as the next byte (byte N+1 carries the reply to the request made at the end of byte N).
REQ-019 On every other sck falling edge inside a transaction, tx_shift SHALL shift left by one; spi_miso = tx_shift[7], registered.
REQ-020 For byte 0 of every transaction, tx_shift SHALL be 8'h00 (it is loaded on the cs_n falling edge).
REQ-021 spi_miso_oe SHALL be 1 only while synchronized cs_n is low; spi_miso SHALL be 0 while spi_miso_oe is 0.
REQ-022 A cs_n rising edge mid-byte (bit_cnt != 0) SHALL discard the partial byte: no rd_valid and no wr_valid; bit_cnt clears.
REQ-023 sck edges while cs_n is high SHALL be ignored.
REQ-024 If a cs_n falling edge and an sck edge are detected in the same cycle, the cs_n handling SHALL take precedence and the sck edge SHALL be ignored.
REQ-025 There SHALL be no limit on transaction length; byte boundaries repeat every 8 rising edges.
REQ-026 Latency from the 8th SCK pin rising edge to rd_valid SHALL be SYNC_STAGES+2 clk cycles.

Reset
REQ-027 While reset_n=0 at posedge clk, the block SHALL set start=0, rd_valid=0, wr_valid=0, rd_data=8'h00, spi_miso=0, spi_miso_oe=0, bit_cnt=0, tx_shift=8'h00, and all synchronizer stages to idle (cs_n=1, sck=0, mosi=0).
REQ-028 After reset_n is deasserted mid-transaction, no start, rd_valid or wr_valid SHALL be issued until the next cs_n falling edge.

Structure
REQ-029 A shared package fcart_pkg SHALL hold the command byte constants (CMD_READ_MEM=0, CMD_WRITE_MEM=1, CMD_READ_REG=2, CMD_WRITE_REG=3) used by this block's consumer and testbench.
REQ-030 One sub-module, sync_ff (parameterised depth and reset value), SHALL implement the pad synchronizers.
REQ-031 The rest of the block SHALL be flat: edge detect, rx path and tx path in one module.

Verification (SCK half-period = 4 clk unless stated)
REQ-032 CS low, MOSI 8'hA5 -> start pulse once; rd_valid once with rd_data=8'hA5; wr_valid one cycle later.
REQ-033 3-byte transfer, consumer returns wr_data=8'h3C on the 1st wr_valid and 8'hC3 on the 2nd -> MISO bytes 00, 3C, C3.
REQ-034 CS rises after 5 bits, then a new transaction sends 8'h01 -> no pulses for the partial byte; rd_data=8'h01 with a fresh start.
REQ-035 SCK toggling with CS high, MOSI=1 -> no rd_valid, spi_miso_oe=0, spi_miso=0.
REQ-036 reset_n pulsed low after 12 bits -> outputs hit reset values; remaining bits produce no pulses; next transaction decodes 8'h02 correctly.
REQ-037 Measure the 8th SCK rising edge to rd_valid -> exactly SYNC_STAGES+2 cycles for SYNC_STAGES=2 and 3.
